// File: rtl/input_sched_pkg.sv
// Shared constants for the input command scheduler: command codes, source bits,
// pending-bit indices, scheduler state encoding and the index-to-command lookup.
package input_sched_pkg;

    localparam logic SRC_PAD   = 1'b0;
    localparam logic SRC_BOARD = 1'b1;

    localparam logic [2:0] CODE_LEFT  = 3'd0;
    localparam logic [2:0] CODE_RIGHT = 3'd1;
    localparam logic [2:0] CODE_DOWN  = 3'd2;
    localparam logic [2:0] CODE_UP    = 3'd3;
    localparam logic [2:0] CODE_START = 3'd4;

    localparam int PEND_PAD_S  = 0;
    localparam int PEND_PAD_R  = 1;
    localparam int PEND_PAD_L  = 2;
    localparam int PEND_PAD_D  = 3;
    localparam int PEND_BTTN_D = 4;
    localparam int PEND_BTTN_R = 5;
    localparam int PEND_BTTN_L = 6;
    localparam int PEND_BTTN_U = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_FULL = 2'd2
    } sched_state_e;

    function automatic logic [3:0] idx_to_cmd(input logic [2:0] idx);
        logic [3:0] c;
        case (idx)
            3'd0:    c = {SRC_PAD,   CODE_START};
            3'd1:    c = {SRC_PAD,   CODE_RIGHT};
            3'd2:    c = {SRC_PAD,   CODE_LEFT};
            3'd3:    c = {SRC_PAD,   CODE_DOWN};
            3'd4:    c = {SRC_BOARD, CODE_DOWN};
            3'd5:    c = {SRC_BOARD, CODE_RIGHT};
            3'd6:    c = {SRC_BOARD, CODE_LEFT};
            default: c = {SRC_BOARD, CODE_UP};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with occupancy count; head reads as zero while empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign do_push = push_i && (cnt_q != FULL_CNT);
    assign do_pop  = pop_i && (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
        else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    assign valid_o = (cnt_q != '0);
    assign data_o  = valid_o ? mem_q[rd_q] : '0;
    assign count_o = cnt_q;

endmodule

// File: rtl/input_cmd_scheduler.sv
// Round-robin scheduler serialising eight debounced ticks into a command FIFO.
// Optional per-source lockout window enabled by defining INPUT_SCHED_LOCKOUT_EN.
module input_cmd_scheduler
    import input_sched_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int LOCKOUT_CYCLES = 650000
) (
    input  logic                              pclk,
    input  logic                              rst,
    input  logic                              pad_Sd,
    input  logic                              pad_Rd,
    input  logic                              pad_Ld,
    input  logic                              pad_Dd,
    input  logic                              bttn_Dd,
    input  logic                              bttn_Rd,
    input  logic                              bttn_Ld,
    input  logic                              bttn_Ud,
    output logic [3:0]                        cmd,
    output logic                              cmd_valid,
    input  logic                              cmd_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              overrun,
    input  logic                              clr_ovr
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || LOCKOUT_CYCLES < 1) begin : g_param_err
        $error("input_cmd_scheduler: illegal FIFO_DEPTH or LOCKOUT_CYCLES");
    end

    sched_state_e     state_q, state_d;
    logic [7:0]       pend_q, pend_d, tick_raw, tick_eff, gnt_oh;
    logic [2:0]       rr_q, rr_d, gnt_idx, scan_idx;
    logic             gnt_found, grant_en, grant, pop, ovr_q, ovr_d;
    logic [CNT_W-1:0] cnt_next;

    assign tick_raw = {bttn_Ud, bttn_Ld, bttn_Rd, bttn_Dd, pad_Dd, pad_Ld, pad_Rd, pad_Sd};

`ifdef INPUT_SCHED_LOCKOUT_EN
    localparam int LK_W = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [LK_W-1:0] LK_LOAD = LK_W'(LOCKOUT_CYCLES - 1);
    logic [LK_W-1:0] pad_lk_q, brd_lk_q;

    // A locked source drops its ticks before capture, so they can neither set pend nor overrun.
    assign tick_eff = tick_raw & ~{{4{brd_lk_q != '0}}, {4{pad_lk_q != '0}}};

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            pad_lk_q <= '0;
            brd_lk_q <= '0;
        end else begin
            if (grant && !gnt_idx[2]) pad_lk_q <= LK_LOAD;
            else if (pad_lk_q != '0)  pad_lk_q <= pad_lk_q - 1'b1;
            if (grant && gnt_idx[2])  brd_lk_q <= LK_LOAD;
            else if (brd_lk_q != '0)  brd_lk_q <= brd_lk_q - 1'b1;
        end
    end
`else
    assign tick_eff = tick_raw;
`endif

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = rr_q;
        scan_idx  = rr_q;
        for (int i = 0; i < 8; i++) begin
            scan_idx = rr_q + 3'(i);
            if (!gnt_found && pend_q[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    assign grant  = grant_en && gnt_found;
    assign gnt_oh = grant ? (8'b1 << gnt_idx) : 8'b0;
    assign pop    = cmd_valid && cmd_ready;

    // A tick on the bit being granted is a fresh event, not an overrun.
    assign pend_d = (pend_q & ~gnt_oh) | tick_eff;
    assign ovr_d  = clr_ovr ? 1'b0 : (ovr_q | (|(tick_eff & pend_q & ~gnt_oh)));
    assign rr_d   = grant ? gnt_idx + 3'd1 : rr_q;

    assign cnt_next = fifo_count + CNT_W'(grant) - CNT_W'(pop);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            rr_q    <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            rr_q    <= rr_d;
            ovr_q   <= ovr_d;
        end
    end

    // State tracks the post-edge pend/occupancy, so ARB already means "grant this cycle".
    always_comb begin
        state_d = state_q;
        if (pend_d == '0)            state_d = ST_IDLE;
        else if (cnt_next == FULL_CNT) state_d = ST_FULL;
        else                         state_d = ST_ARB;
    end

    always_comb begin
        grant_en = (state_q == ST_ARB);
    end

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (4),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (pclk),
        .rst     (rst),
        .push_i  (grant),
        .data_i  (idx_to_cmd(gnt_idx)),
        .pop_i   (cmd_ready),
        .data_o  (cmd),
        .valid_o (cmd_valid),
        .count_o (fifo_count)
    );

    assign overrun = ovr_q;

endmodule
